// File: rtl/i2c_codec_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_responder_pkg
//  Description : Shared audio definitions. Holds the I2C responder state
//                encoding, the WM8731 register-file geometry, the
//                register-reset address and the power-on default table.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_codec_responder_pkg;

  // Frame-level states of the write-only responder
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ACK_A   = 3'd2,
    BYTE_HI = 3'd3,
    ACK_HI  = 3'd4,
    BYTE_LO = 3'd5,
    ACK_LO  = 3'd6,
    IGNORE  = 3'd7
  } i2c_state_t;

  // Register file holds R0..R9
  localparam int         NUM_REGS       = 10;
  localparam logic [6:0] LAST_REG_ADDR  = 7'd9;
  localparam logic [3:0] LAST_RD_ADDR   = 4'd9;

  // Writing any data to R15 restores every register to its default
  localparam logic [6:0] REG_RESET_ADDR = 7'h0F;

  // WM8731 power-on register defaults, indexed by register number
  function automatic logic [8:0] wm8731_default(input logic [3:0] idx);
    logic [8:0] v;
    case (idx)
      4'd0:    v = 9'h097;
      4'd1:    v = 9'h097;
      4'd2:    v = 9'h079;
      4'd3:    v = 9'h079;
      4'd4:    v = 9'h00A;
      4'd5:    v = 9'h008;
      4'd6:    v = 9'h09F;
      4'd7:    v = 9'h00A;
      4'd8:    v = 9'h000;
      4'd9:    v = 9'h000;
      default: v = 9'h000;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_codec_responder_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_sync
//  Description : Brings the asynchronous SCL/SDA lines into the system clock
//                domain and derives SCL edges plus START/STOP conditions from
//                the synchronized levels.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one history flop per line; idle bus level is 1
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync[0] <= i_scl;
      r_sda_sync[0] <= i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  // SDA only counts as START/STOP when SCL stayed high across the change
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_responder
//  Description : Write-only I2C target for a WM8731-style codec control port.
//                Accepts 3-byte frames (device address, {reg[6:0],d[8]},
//                d[7:0]), ACKs them, and updates a 10-entry register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_responder
  import i2c_codec_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic [3:0] o_frame_cnt
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_t r_state,     w_state_nxt;
  logic [2:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0] r_shift,     w_shift_nxt;
  logic [7:0] r_byte_hi,   w_byte_hi_nxt;
  logic       r_sda_oen,   w_sda_oen_nxt;
  logic       r_ack_phase, w_ack_phase_nxt;
  logic       r_commit,    w_commit_nxt;
  logic       r_busy,      w_busy_nxt;

  logic [7:0] w_byte;
  logic       w_last_bit;
  logic       w_addr_match;

  // Byte as it will look once the bit sampled on this SCL rise is shifted in
  assign w_byte       = {r_shift[6:0], w_sda};
  assign w_last_bit   = (r_bit_cnt == 3'd7);
  assign w_addr_match = (w_byte[7:1] == DEV_ADDR) && !w_byte[0];

  // Frame state and shift registers; reset releases SDA on the same edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_byte_hi   <= 8'h00;
      r_sda_oen   <= 1'b0;
      r_ack_phase <= 1'b0;
      r_commit    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_hi   <= w_byte_hi_nxt;
      r_sda_oen   <= w_sda_oen_nxt;
      r_ack_phase <= w_ack_phase_nxt;
      r_commit    <= w_commit_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state logic: bus conditions pre-empt any bit-level activity
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_byte_hi_nxt   = r_byte_hi;
    w_sda_oen_nxt   = r_sda_oen;
    w_ack_phase_nxt = r_ack_phase;
    w_commit_nxt    = 1'b0;
    w_busy_nxt      = r_busy;

    if (w_start) begin
      w_state_nxt     = ADDR;
      w_bit_cnt_nxt   = 3'd0;
      w_sda_oen_nxt   = 1'b0;
      w_ack_phase_nxt = 1'b0;
      w_busy_nxt      = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = IDLE;
      w_bit_cnt_nxt   = 3'd0;
      w_sda_oen_nxt   = 1'b0;
      w_ack_phase_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
    end else begin
      case (r_state)
        ADDR, BYTE_HI, BYTE_LO: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              case (r_state)
                ADDR:    w_state_nxt = w_addr_match ? ACK_A : IGNORE;
                BYTE_HI: begin
                  w_byte_hi_nxt = w_byte;
                  w_state_nxt   = ACK_HI;
                end
                default: w_state_nxt = ACK_LO;
              endcase
            end
          end
        end
        ACK_A, ACK_HI, ACK_LO: begin
          // First SCL fall grabs SDA, the second one (end of ACK bit) lets go
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_oen_nxt   = 1'b1;
              w_ack_phase_nxt = 1'b1;
            end else begin
              w_sda_oen_nxt   = 1'b0;
              w_ack_phase_nxt = 1'b0;
              w_bit_cnt_nxt   = 3'd0;
              case (r_state)
                ACK_A:  w_state_nxt = BYTE_HI;
                ACK_HI: w_state_nxt = BYTE_LO;
                default: begin
                  w_state_nxt  = IGNORE;
                  w_commit_nxt = 1'b1;
                end
              endcase
            end
          end
        end
        default: begin
          w_sda_oen_nxt   = 1'b0;
          w_ack_phase_nxt = 1'b0;
        end
      endcase
    end
  end

  logic [6:0] w_commit_addr;
  logic [8:0] w_commit_data;

  assign w_commit_addr = r_byte_hi[7:1];
  assign w_commit_data = {r_byte_hi[0], r_shift};

  logic       r_wr_valid;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;
  logic [3:0] r_frame_cnt;
  logic [8:0] r_regs [NUM_REGS];
  logic [8:0] r_rd_data;

  // Completed-frame publication, register file update and frame counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 7'h00;
      r_wr_data   <= 9'h000;
      r_frame_cnt <= 4'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= wm8731_default(4'(i));
      end
    end else begin
      r_wr_valid <= r_commit;
      if (r_commit) begin
        r_wr_addr <= w_commit_addr;
        r_wr_data <= w_commit_data;
        if (r_frame_cnt != 4'hF) begin
          r_frame_cnt <= r_frame_cnt + 4'd1;
        end
        if (w_commit_addr == REG_RESET_ADDR) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= wm8731_default(4'(i));
          end
        end else if (w_commit_addr <= LAST_REG_ADDR) begin
          r_regs[w_commit_addr[3:0]] <= w_commit_data;
        end
      end
    end
  end

  // Registered read port; addresses past R9 read as zero
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= 9'h000;
    end else if (i_rd_addr <= LAST_RD_ADDR) begin
      r_rd_data <= r_regs[i_rd_addr];
    end else begin
      r_rd_data <= 9'h000;
    end
  end

  assign o_sda_oen   = r_sda_oen;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_rd_data   = r_rd_data;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit I2C target address the block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each I2C line.
REQ-003 SHALL have port i_clk, input, 1 bit: the only clock, 50 MHz system clock.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_scl, input, 1 bit: asynchronous I2C clock from the initiator.
REQ-006 SHALL have port i_sda, input, 1 bit: asynchronous I2C data line, resolved bus value.
REQ-007 SHALL have port o_sda_oen, output, 1 bit: 1 = pull SDA low (ACK); 0 = release the line.
REQ-008 SHALL have port o_wr_valid, output, 1 bit: one-cycle pulse when a complete write frame is received.
REQ-009 SHALL have port o_wr_addr, output, 7 bits: register address of the last frame.
REQ-010 SHALL have port o_wr_data, output, 9 bits: register data of the last frame.
REQ-011 SHALL have port i_rd_addr, input, 4 bits: register file read address.
REQ-012 SHALL have port o_rd_data, output, 9 bits: register file read data, 1-cycle latency.
REQ-013 SHALL have port o_busy, output, 1 bit: high from a START until the next STOP.
REQ-014 SHALL have port o_frame_cnt, output, 4 bits: count of accepted frames, saturating at 15.

Function
REQ-015 SHALL pass SCL and SDA through SYNC_STAGES flops, then detect edges on the synchronized values.
REQ-016 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-017 SHALL give START/STOP detection priority over data sampling when they occur in the same cycle.
REQ-018 SHALL sample SDA on the SCL rising edge and shift bits in MSB first.
REQ-019 SHALL implement states IDLE, ADDR, ACK_A, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO and IGNORE.
REQ-020 SHALL move from any state to ADDR on START (repeated START included), clearing the bit counter.
REQ-021 SHALL move from any state to IDLE on STOP; an incomplete frame at that point SHALL produce no write.
REQ-022 In ADDR, after 8 bits, the block SHALL go to ACK_A when the address equals DEV_ADDR and R/W=0, and to IGNORE otherwise, with no ACK.
REQ-023 A frame SHALL be the WM8731 format: BYTE_HI = {reg_addr[6:0], data[8]}, BYTE_LO = data[7:0].
REQ-024 For each ACK state, o_sda_oen SHALL assert on the SCL falling edge after the 8th bit and release on the next SCL falling edge.
REQ-025 After ACK_LO releases, the block SHALL update o_wr_addr/o_wr_data and pulse o_wr_valid on the following cycle, then go to IGNORE.
REQ-026 In IGNORE, the block SHALL never drive SDA, so any extra bytes are NACKed.
REQ-027 The register file SHALL hold R0..R9, 9 bits each; a frame addressing R0..R9 SHALL write that register.
REQ-028 A frame addressing R15 SHALL restore all registers to WM8731 defaults: 097,097,079,079,00A,008,09F,00A,000,000 (hex).
REQ-029 Frames to any other address SHALL be ACKed and pulse o_wr_valid but SHALL NOT change the register file.
REQ-030 i_rd_addr above 9 SHALL return 9'h000.
REQ-031 o_frame_cnt SHALL increment on every o_wr_valid and hold at 15.

Reset
REQ-032 On reset the block SHALL clear the state to IDLE and drive o_sda_oen=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0 and o_frame_cnt=0.
REQ-033 On reset, o_rd_data SHALL be 0 and the register file SHALL load the defaults of REQ-028.
REQ-034 On reset the synchronizer flops SHALL be set to 1, the idle bus level.
REQ-035 Reset asserted mid-transaction SHALL release SDA in the same clock edge; the aborted frame SHALL produce no write.

Structure
REQ-036 The state enum, the WM8731 register default table and the R15 address constant SHALL live in the shared audio package.
REQ-037 The synchronizer, edge and START/STOP detection SHALL be one sub-module, i2c_line_sync.

Verification
REQ-038 Frame 34 1E 06 at 100 kHz (R15 reset) -> three ACKs, o_wr_valid=1 for one cycle with addr=0x0F, R4 reads 0x00A.
REQ-039 Frame 34 08 15 -> o_wr_addr=0x04, o_wr_data=0x015, o_rd_data for address 4 = 0x015 one cycle after the read.
REQ-040 Address byte 36 (wrong device) -> no ACK, o_sda_oen stays 0, no o_wr_valid, o_busy=1 until STOP.
REQ-041 STOP after BYTE_HI ACK -> no o_wr_valid, state IDLE, register file unchanged.
REQ-042 Sequence 34 12 AA, repeated START, 34 14 55 -> two write pulses, R9=0x0AA and R10 access ignored, o_frame_cnt=2.
REQ-043 Reset asserted during the second ACK -> o_sda_oen=0 on the next clock, registers return to defaults.
